// File: rtl/wb_arbiter_nx1.sv
// N-to-1 Wishbone arbiter: registered round-robin grant held for the whole bus cycle, combinational datapath.
// Optional wait-state timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_nx1 #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_INITIATORS   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]   t_adr,
  input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   t_dat_w,
  output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]   t_dat_r,
  input  logic [N_INITIATORS-1:0]                 t_cyc,
  input  logic [N_INITIATORS-1:0]                 t_stb,
  input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0] t_sel,
  input  logic [N_INITIATORS-1:0]                 t_we,
  output logic [N_INITIATORS-1:0]                 t_ack,
  output logic [N_INITIATORS-1:0]                 t_err,
  output logic [WB_ADDR_WIDTH-1:0]                i_adr,
  output logic [WB_DATA_WIDTH-1:0]                i_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]                i_dat_r,
  output logic                                    i_cyc,
  output logic                                    i_stb,
  output logic [WB_DATA_WIDTH/8-1:0]              i_sel,
  output logic                                    i_we,
  input  logic                                    i_ack,
  input  logic                                    i_err,
  output logic                                    tmo
);

  localparam int ID_W  = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;
  localparam int SEL_W = WB_DATA_WIDTH / 8;

  logic            gnt_valid_r;
  logic [ID_W-1:0] gnt_id_r;
  logic [ID_W-1:0] last_id_r;
  logic            owner_cyc_s;
  logic            owner_stb_s;
  logic            arb_s;
  logic            found_s;
  logic [ID_W-1:0] win_id_s;
  logic            tmo_s;

  // Forward mux: the granted initiator's slices, or all zero when no grant.
  always_comb begin
    owner_cyc_s = 1'b0;
    owner_stb_s = 1'b0;
    i_adr       = '0;
    i_dat_w     = '0;
    i_sel       = '0;
    i_we        = 1'b0;
    for (int k = 0; k < N_INITIATORS; k++) begin
      if (gnt_valid_r && (gnt_id_r == ID_W'(k))) begin
        owner_cyc_s = t_cyc[k];
        owner_stb_s = t_stb[k];
        i_adr       = t_adr[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        i_dat_w     = t_dat_w[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        i_sel       = t_sel[k*SEL_W +: SEL_W];
        i_we        = t_we[k];
      end else begin
      end
    end
  end

  assign i_cyc = owner_cyc_s;
  assign i_stb = owner_stb_s & ~tmo_s;
  assign tmo   = tmo_s;
  assign arb_s = ~gnt_valid_r | ~owner_cyc_s;

  // Round-robin search: smallest distance from last_id+1 (mod N) among requesters wins.
  always_comb begin
    int best_s;
    int dist_s;
    best_s   = N_INITIATORS;
    dist_s   = 0;
    found_s  = 1'b0;
    win_id_s = '0;
    for (int k = 0; k < N_INITIATORS; k++) begin
      dist_s = (k + N_INITIATORS - 1 - int'(last_id_r)) % N_INITIATORS;
      if (t_cyc[k] && (dist_s < best_s)) begin
        best_s   = dist_s;
        found_s  = 1'b1;
        win_id_s = ID_W'(k);
      end else begin
      end
    end
  end

  // Grant state: re-arbitrate only when the bus is free or the owner released cyc.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= '0;
      last_id_r   <= ID_W'(N_INITIATORS - 1);
    end else if (arb_s) begin
      if (found_s) begin
        gnt_valid_r <= 1'b1;
        gnt_id_r    <= win_id_s;
        last_id_r   <= win_id_s;
      end else begin
        gnt_valid_r <= 1'b0;
      end
    end else begin
      gnt_valid_r <= gnt_valid_r;
    end
  end

  // Return path: only the granted initiator sees ack/err/data; late responses without a grant are dropped.
  always_comb begin
    t_ack   = '0;
    t_err   = '0;
    t_dat_r = '0;
    for (int k = 0; k < N_INITIATORS; k++) begin
      if (gnt_valid_r && (gnt_id_r == ID_W'(k))) begin
        t_ack[k] = i_ack;
        t_err[k] = i_err | tmo_s;
        t_dat_r[k*WB_DATA_WIDTH +: WB_DATA_WIDTH] = i_dat_r;
      end else begin
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_r;

  // An ack in the would-be firing cycle takes precedence over the timeout.
  assign tmo_s = owner_cyc_s & owner_stb_s & ~i_ack & ~i_err &
                 (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: counts unanswered strobe cycles of the current owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 16'd0;
    end else if (arb_s || i_ack || i_err || tmo_s) begin
      wait_cnt_r <= 16'd0;
    end else if (owner_cyc_s && owner_stb_s) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_nx1.sv
// Scoreboard bench for wb_arbiter_nx1 (2 initiators, TIMEOUT_CYCLES=8); timeout cases follow WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_nx1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] t_adr = '0;
  logic [63:0] t_dat_w = '0;
  logic [63:0] t_dat_r;
  logic [1:0]  t_cyc = '0;
  logic [1:0]  t_stb = '0;
  logic [7:0]  t_sel = '0;
  logic [1:0]  t_we = '0;
  logic [1:0]  t_ack;
  logic [1:0]  t_err;
  logic [31:0] i_adr;
  logic [31:0] i_dat_w;
  logic [31:0] i_dat_r;
  logic        i_cyc;
  logic        i_stb;
  logic [3:0]  i_sel;
  logic        i_we;
  logic        i_ack;
  logic        i_err;
  logic        tmo;

  wb_arbiter_nx1 #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_INITIATORS(2), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_sel(t_sel), .t_we(t_we), .t_ack(t_ack), .t_err(t_err),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_cyc(i_cyc), .i_stb(i_stb),
    .i_sel(i_sel), .i_we(i_we), .i_ack(i_ack), .i_err(i_err), .tmo(tmo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [63:0] dat;
    logic        tmo;
    logic        stb;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_num = 0;
  int          rise_cyc = 0;
  int          resp_cyc = 0;
  int          req_cyc[2];
  int          idle_cnt = 0;
  int          fair_rises = 0;
  bit          fair_phase = 1'b0;

  // Target model: acks after tgt_lat strobe cycles unless tgt_never is set.
  int          tgt_lat = 1;
  bit          tgt_never = 1'b0;
  bit          force_ack = 1'b0;
  logic        tgt_ack = 1'b0;
  int          tgt_cnt = 0;
  logic [31:0] tgt_data = 32'h0;

  assign i_ack   = tgt_ack | force_ack;
  assign i_err   = 1'b0;
  assign i_dat_r = tgt_data;

  always @(posedge clock) begin
    cyc_num <= cyc_num + 1;
    if (i_cyc && i_stb && !tgt_ack && !tgt_never) begin
      if (tgt_cnt == tgt_lat - 1) begin
        tgt_ack <= 1'b1;
        tgt_cnt <= 0;
      end else begin
        tgt_cnt <= tgt_cnt + 1;
      end
    end else begin
      tgt_ack <= 1'b0;
      tgt_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int k, input bit err, input bit to, input logic [31:0] d);
    exp_t e;
    e.ack = err ? 2'b00 : (2'b01 << k);
    e.err = err ? (2'b01 << k) : 2'b00;
    e.dat = (k == 0) ? {32'h0, d} : {d, 32'h0};
    e.tmo = to;
    e.stb = ~to;
    return e;
  endfunction

  // Monitor: every ack/err/tmo the DUT presents is matched against the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && ((|t_ack) || (|t_err) || tmo)) begin
        resp_cyc = cyc_num;
        if (sb_q.size() == 0) begin
          chk("unexpected_response", {60'h0, t_err, t_ack}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_ack", {62'h0, t_ack}, {62'h0, e.ack});
          chk("sb_err", {62'h0, t_err}, {62'h0, e.err});
          chk("sb_dat_r", t_dat_r, e.dat);
          chk("sb_tmo", {63'h0, tmo}, {63'h0, e.tmo});
          chk("sb_i_stb", {63'h0, i_stb}, {63'h0, e.stb});
        end
      end
    end
  end

  // Bus tracker: records i_cyc rise time and checks the idle gap at each handover.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (i_cyc && !prev) begin
        rise_cyc = cyc_num;
        if (fair_phase && fair_rises > 0) chk("handover_idle", 64'(idle_cnt), 64'd1);
        if (fair_phase) fair_rises++;
        idle_cnt = 0;
      end
      if (!i_cyc) idle_cnt++;
      prev = i_cyc;
    end
  end

  task automatic master(input int k, input logic [31:0] adr, input int beats);
    int w;
    @(posedge clock); #1;
    req_cyc[k] = cyc_num;
    t_adr[k*32 +: 32] = adr;
    t_dat_w[k*32 +: 32] = ~adr;
    t_sel[k*4 +: 4] = 4'hF;
    t_we[k] = 1'b0;
    t_cyc[k] = 1'b1;
    t_stb[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      w = 0;
      do begin
        @(negedge clock);
        w++;
      end while (!(t_ack[k] || t_err[k]) && w < 60);
      if (w >= 60) chk("master_wait_bound", 64'(k), 64'hFF);
      @(posedge clock); #1;
    end
    t_cyc[k] = 1'b0;
    t_stb[k] = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_i_cyc", {63'h0, i_cyc}, 64'h0);
    chk("rst_i_adr", {32'h0, i_adr}, 64'h0);
    chk("rst_t_ack", {62'h0, t_ack}, 64'h0);
    chk("rst_tmo", {63'h0, tmo}, 64'h0);
    @(posedge clock); #1 reset = 1'b1;

    // Basic read, target acks 2 cycles after i_stb
    tgt_lat = 2; tgt_data = 32'hCAFEF00D;
    sb_q.push_back(mk(0, 1'b0, 1'b0, 32'hCAFEF00D));
    master(0, 32'h1000, 1);
    chk("grant_latency", 64'(rise_cyc - req_cyc[0]), 64'd1);
    chk("ack_latency", 64'(resp_cyc - rise_cyc), 64'd2);

    // Fairness: both request continuously, 1-beat cycles; last owner was 0 so 1 goes first here
    tgt_lat = 1; tgt_data = 32'h5A5A0001;
    fair_phase = 1'b1; fair_rises = 0;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk((i + 1) % 2, 1'b0, 1'b0, 32'h5A5A0001));
    fork
      begin master(0, 32'h2000, 1); master(0, 32'h2004, 1); end
      begin master(1, 32'h3000, 1); master(1, 32'h3004, 1); end
    join
    fair_phase = 1'b0;

    // Grant hold: initiator 1 bursts 4 beats while 0 requests
    tgt_data = 32'h0BAD0BEE;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(1, 1'b0, 1'b0, 32'h0BAD0BEE));
    sb_q.push_back(mk(0, 1'b0, 1'b0, 32'h0BAD0BEE));
    fork
      master(1, 32'h4000, 4);
      begin repeat (2) @(posedge clock); master(0, 32'h4100, 1); end
    join

    // Reset mid-cycle with initiator 0 owning, late ack forced during reset
    tgt_never = 1'b1;
    @(posedge clock); #1;
    t_adr[31:0] = 32'h5000; t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("pre_reset_i_cyc", {63'h0, i_cyc}, 64'h1);
    #2 force_ack = 1'b1; reset = 1'b0;
    #1;
    chk("midrst_i_cyc", {63'h0, i_cyc}, 64'h0);
    chk("midrst_i_stb", {63'h0, i_stb}, 64'h0);
    chk("midrst_t_ack", {62'h0, t_ack}, 64'h0);
    chk("midrst_t_err", {62'h0, t_err}, 64'h0);
    t_cyc = '0; t_stb = '0; force_ack = 1'b0; tgt_never = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    tgt_data = 32'h12345678;
    sb_q.push_back(mk(0, 1'b0, 1'b0, 32'h12345678));
    sb_q.push_back(mk(1, 1'b0, 1'b0, 32'h12345678));
    fork
      master(0, 32'h6000, 1);
      master(1, 32'h6100, 1);
    join

    // Ack on the 8th wait cycle: normal ack, never a timeout
    tgt_lat = 7; tgt_data = 32'hA5A5A5A5;
    sb_q.push_back(mk(0, 1'b0, 1'b0, 32'hA5A5A5A5));
    master(0, 32'h7000, 1);
    chk("preempt_ack_cycle", 64'(resp_cyc - rise_cyc), 64'd7);

`ifdef WB_ARB_TIMEOUT_EN
    // Target never acks: err+tmo on the 8th wait cycle with i_stb low
    tgt_never = 1'b1;
    sb_q.push_back(mk(1, 1'b1, 1'b1, 32'hA5A5A5A5));
    master(1, 32'h8000, 1);
    chk("timeout_cycle", 64'(resp_cyc - rise_cyc), 64'd7);
    tgt_never = 1'b0;
`else
    // Without the timeout a stall never errors
    begin
      logic seen = 1'b0;
      tgt_never = 1'b1;
      @(posedge clock); #1;
      t_adr[63:32] = 32'h8000; t_cyc[1] = 1'b1; t_stb[1] = 1'b1;
      repeat (20) begin
        @(negedge clock);
        if ((|t_err) || tmo || (|t_ack)) seen = 1'b1;
      end
      chk("stall_no_err", {63'h0, seen}, 64'h0);
      chk("stall_still_cyc", {63'h0, i_cyc}, 64'h1);
      @(posedge clock); #1 t_cyc = '0; t_stb = '0; tgt_never = 1'b0;
    end
`endif

    repeat (3) @(posedge clock);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
